// File: rtl/cc_action_sequencer_if.sv
// Signal bundle between the CC game sequencer, the action source and the board engines.
// Handshakes: each *_start is a registered one-cycle request; the engine answers with a one-cycle
// *_done no earlier than the following cycle, and legal/hit/count are meaningful only alongside their done.
interface cc_action_sequencer_if;
   logic       in_valid_2;
   logic [5:0] in_starting_pos;
   logic [1:0] in_action;
   logic       board_loaded;
   logic       swap_start;
   logic [5:0] swap_pos;
   logic [1:0] swap_dir;
   logic       swap_done;
   logic       swap_legal;
   logic       scan_start;
   logic       scan_done;
   logic       scan_hit;
   logic [5:0] scan_count;
   logic       drop_start;
   logic       drop_done;
   logic       out_valid;
   logic [6:0] out_score;
   logic       busy;
   logic [1:0] err;
   logic [2:0] dbg_state;

   modport master (
      input  in_valid_2, in_starting_pos, in_action, board_loaded,
      input  swap_done, swap_legal, scan_done, scan_hit, scan_count, drop_done,
      output swap_start, swap_pos, swap_dir, scan_start, drop_start,
      output out_valid, out_score, busy, err, dbg_state
   );

   modport slave (
      output in_valid_2, in_starting_pos, in_action, board_loaded,
      output swap_done, swap_legal, scan_done, scan_hit, scan_count, drop_done,
      input  swap_start, swap_pos, swap_dir, scan_start, drop_start,
      input  out_valid, out_score, busy, err, dbg_state
   );
endinterface

// File: rtl/cc_action_sequencer.sv
// Game control FSM for CC: buffers player actions, drives swap/scan/drop engines per action,
// accumulates a saturating score and reports it with a one-cycle pulse.
module cc_action_sequencer #(
   parameter int ACT_NUM     = 10,
   parameter int MAX_CASCADE = 16,
   parameter int LAT_LIMIT   = 480
) (
   input logic                   clk,
   input logic                   rst,
   cc_action_sequencer_if.master bus
);
   localparam int PTR_W = $clog2(ACT_NUM);
   localparam int CNT_W = $clog2(ACT_NUM + 1);
   localparam int CAS_W = $clog2(MAX_CASCADE + 1);
   localparam int WD_W  = $clog2(LAT_LIMIT + 1);

   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(ACT_NUM - 1);
   localparam logic [CNT_W-1:0] ACT_MAX  = CNT_W'(ACT_NUM);
   localparam logic [CAS_W-1:0] CAS_MAX  = CAS_W'(MAX_CASCADE);
   localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(LAT_LIMIT);
   localparam logic [WD_W-1:0]  WD_TRIP  = WD_W'(LAT_LIMIT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_SWAP  = 3'd2,
      S_SCAN  = 3'd3,
      S_DROP  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t           state;
   logic [7:0]       fifo_mem [ACT_NUM];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] fifo_cnt;
   logic [CNT_W-1:0] acc_cnt;
   logic [CNT_W-1:0] act_done;
   logic [CAS_W-1:0] casc_cnt;
   logic [WD_W-1:0]  wd_cnt;
   logic [6:0]       score;
   logic [7:0]       score_sum;

   logic             swap_start;
   logic [5:0]       swap_pos;
   logic [1:0]       swap_dir;
   logic             scan_start;
   logic             drop_start;
   logic             out_valid;
   logic [6:0]       out_score;
   logic             busy;
   logic [1:0]       err;

   logic fifo_full, fifo_empty, push_ok, push_drop, fifo_pop, timeout;

   assign fifo_full  = (fifo_cnt == ACT_MAX);
   assign fifo_empty = (fifo_cnt == '0);
   assign push_drop  = bus.in_valid_2 && (fifo_full || (acc_cnt == ACT_MAX));
   assign push_ok    = bus.in_valid_2 && !push_drop;
   // An accepted action restarts the watchdog, so it also cancels a trip in the same cycle.
   assign timeout    = (state != S_IDLE) && (state != S_DONE) && !push_ok && (wd_cnt == WD_TRIP);
   assign fifo_pop   = (state == S_FETCH) && !timeout && (act_done != ACT_MAX) && !fifo_empty;
   assign score_sum  = {1'b0, score} + {2'b00, bus.scan_count};

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push_ok) begin
            fifo_mem[wr_ptr] <= {bus.in_starting_pos, bus.in_action};
            wr_ptr           <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
         end
         if (fifo_pop) begin
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
         end
         case ({push_ok, fifo_pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         acc_cnt    <= '0;
         act_done   <= '0;
         casc_cnt   <= '0;
         wd_cnt     <= '0;
         score      <= '0;
         swap_start <= 1'b0;
         swap_pos   <= '0;
         swap_dir   <= '0;
         scan_start <= 1'b0;
         drop_start <= 1'b0;
         out_valid  <= 1'b0;
         out_score  <= '0;
         busy       <= 1'b0;
         err        <= '0;
      end else begin
         swap_start <= 1'b0;
         scan_start <= 1'b0;
         drop_start <= 1'b0;
         out_valid  <= 1'b0;
         out_score  <= '0;

         if (push_ok) begin
            acc_cnt <= acc_cnt + 1'b1;
            wd_cnt  <= '0;
         end else if ((state != S_IDLE) && (wd_cnt != WD_MAX)) begin
            wd_cnt <= wd_cnt + 1'b1;
         end

         // A game start clears the flags first so a drop in the same cycle still sticks.
         if ((state == S_IDLE) && bus.board_loaded) err <= '0;
         if (push_drop) err[1] <= 1'b1;

         if (timeout) begin
            err[0]    <= 1'b1;
            out_valid <= 1'b1;
            out_score <= score;
            state     <= S_DONE;
         end else begin
            unique case (state)
               S_IDLE: begin
                  if (bus.board_loaded) begin
                     score    <= '0;
                     casc_cnt <= '0;
                     act_done <= '0;
                     if (!push_ok) wd_cnt <= '0;
                     busy     <= 1'b1;
                     state    <= S_FETCH;
                  end
               end
               S_FETCH: begin
                  if (act_done == ACT_MAX) begin
                     out_valid <= 1'b1;
                     out_score <= score;
                     state     <= S_DONE;
                  end else if (!fifo_empty) begin
                     {swap_pos, swap_dir} <= fifo_mem[rd_ptr];
                     act_done   <= act_done + 1'b1;
                     swap_start <= 1'b1;
                     state      <= S_SWAP;
                  end
               end
               // A done seen while the start is still high belongs to an earlier request.
               S_SWAP: begin
                  if (bus.swap_done && !swap_start) begin
                     if (bus.swap_legal) begin
                        casc_cnt   <= '0;
                        scan_start <= 1'b1;
                        state      <= S_SCAN;
                     end else begin
                        state <= S_FETCH;
                     end
                  end
               end
               S_SCAN: begin
                  if (bus.scan_done && !scan_start) begin
                     if (bus.scan_hit) begin
                        score      <= (score_sum > 8'd127) ? 7'd127 : score_sum[6:0];
                        casc_cnt   <= casc_cnt + 1'b1;
                        drop_start <= 1'b1;
                        state      <= S_DROP;
                     end else begin
                        state <= S_FETCH;
                     end
                  end
               end
               S_DROP: begin
                  if (bus.drop_done && !drop_start) begin
                     if (casc_cnt < CAS_MAX) begin
                        scan_start <= 1'b1;
                        state      <= S_SCAN;
                     end else begin
                        state <= S_FETCH;
                     end
                  end
               end
               S_DONE: begin
                  acc_cnt <= push_ok ? CNT_W'(1) : '0;
                  busy    <= 1'b0;
                  state   <= S_IDLE;
               end
               default: begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.swap_start = swap_start;
   assign bus.swap_pos   = swap_pos;
   assign bus.swap_dir   = swap_dir;
   assign bus.scan_start = scan_start;
   assign bus.drop_start = drop_start;
   assign bus.out_valid  = out_valid;
   assign bus.out_score  = out_score;
   assign bus.busy       = busy;
   assign bus.err        = err;
   assign bus.dbg_state  = state;
endmodule

// File: tb/tb_cc_action_sequencer.sv
// Directed bench for cc_action_sequencer: scripted engine responders, an action scoreboard and
// hand-computed game scores.
module tb_cc_action_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cc_action_sequencer_if bus ();
   cc_action_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

   int n_tests = 0;
   int n_fail  = 0;

   // Engine behaviour for the current game.
   int         cfg_hits    = 0;
   logic [5:0] cfg_count   = 6'd0;
   int         cfg_illegal = -1;
   bit         cfg_hang    = 1'b0;

   // Observations made by the engine process.
   int unsigned cyc, n_swap, n_scan, n_drop, n_ov, run, max_run;
   int unsigned busy_pre_ov, last_done_cyc, ov_cyc;
   int          swap_num, scan_num;
   logic [7:0]  obs_q[$];

   logic [7:0]  exp_q[$];
   int          obs_rd = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Minimum-latency engines: a start seen in cycle c is answered with done in cycle c+1.
   initial begin : engines
      bit swap_pend, scan_pend, drop_pend;
      swap_pend = 0; scan_pend = 0; drop_pend = 0;
      cyc = 0; n_swap = 0; n_scan = 0; n_drop = 0; n_ov = 0; run = 0; max_run = 0;
      busy_pre_ov = 0; last_done_cyc = 0; ov_cyc = 0; swap_num = 0; scan_num = 0;
      bus.swap_done = 1'b0; bus.swap_legal = 1'b0;
      bus.scan_done = 1'b0; bus.scan_hit = 1'b0; bus.scan_count = 6'd0;
      bus.drop_done = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         bus.swap_done  = 1'b0;
         bus.swap_legal = 1'b0;
         bus.scan_done  = 1'b0;
         bus.scan_hit   = 1'b0;
         bus.scan_count = 6'd0;
         bus.drop_done  = 1'b0;
         if (bus.board_loaded || rst) begin
            swap_pend = 0; scan_pend = 0; drop_pend = 0;
            n_swap = 0; n_scan = 0; n_drop = 0; n_ov = 0; run = 0; max_run = 0;
            busy_pre_ov = 0; swap_num = 0; scan_num = 0;
         end else begin
            if (swap_pend) begin
               bus.swap_done  = 1'b1;
               bus.swap_legal = (swap_num != cfg_illegal);
               swap_pend = 0;
            end
            if (scan_pend) begin
               bus.scan_done  = 1'b1;
               bus.scan_count = cfg_count;
               bus.scan_hit   = (scan_num <= cfg_hits);
               if (!bus.scan_hit) last_done_cyc = cyc;
               scan_pend = 0;
            end
            if (drop_pend && !cfg_hang) begin
               bus.drop_done = 1'b1;
               last_done_cyc = cyc;
               drop_pend = 0;
            end
            if (bus.swap_start) begin
               swap_pend = 1; swap_num++; n_swap++; run = 0; scan_num = 0;
               obs_q.push_back({bus.swap_pos, bus.swap_dir});
            end
            if (bus.scan_start) begin
               scan_pend = 1; scan_num++; n_scan++;
            end
            if (bus.drop_start) begin
               drop_pend = 1; n_drop++; run++;
               if (run > max_run) max_run = run;
            end
         end
         if (bus.out_valid) begin
            if (n_ov == 0) ov_cyc = cyc;
            n_ov++;
         end else if (bus.busy && n_ov == 0) begin
            busy_pre_ov++;
         end
      end
   end

   task automatic set_cfg(input int hits, input logic [5:0] count, input int illegal, input bit hang);
      cfg_hits = hits; cfg_count = count; cfg_illegal = illegal; cfg_hang = hang;
   endtask

   task automatic push_act(input logic [5:0] pos, input logic [1:0] dir, input bit accepted);
      bus.in_valid_2 = 1'b1;
      bus.in_starting_pos = pos;
      bus.in_action = dir;
      if (accepted) exp_q.push_back({pos, dir});
      tick();
      bus.in_valid_2 = 1'b0;
   endtask

   task automatic push_ten(input int g);
      for (int i = 0; i < 10; i++) push_act(6'(g * 9 + i * 5), 2'(i), 1'b1);
   endtask

   task automatic load_board();
      bus.board_loaded = 1'b1;
      tick();
      bus.board_loaded = 1'b0;
   endtask

   task automatic compare_obs(input string tag);
      logic [7:0] exp_a;
      while (obs_rd < obs_q.size()) begin
         if (exp_q.size() > 0) exp_a = exp_q.pop_front();
         else exp_a = 8'hxx;
         check(tag, 32'(obs_q[obs_rd]), 32'(exp_a));
         obs_rd++;
      end
   endtask

   task automatic finish_game(input string tag, input logic [6:0] exp_score, input logic [1:0] exp_err);
      bit seen = 1'b0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         if (bus.out_valid) seen = 1'b1;
         else tick();
      end
      check({tag, "_ov_seen"}, 32'(seen), 32'd1);
      if (seen) begin
         check({tag, "_score"}, 32'(bus.out_score), 32'(exp_score));
         check({tag, "_err"}, 32'(bus.err), 32'(exp_err));
         tick();
         check({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
         check({tag, "_ov_after"}, 32'(bus.out_valid), 32'd0);
         check({tag, "_score_after"}, 32'(bus.out_score), 32'd0);
      end
      repeat (4) tick();
      check({tag, "_ov_pulses"}, n_ov, 32'd1);
      compare_obs({tag, "_act"});
   endtask

   initial begin : main
      bus.in_valid_2 = 1'b0;
      bus.in_starting_pos = 6'd0;
      bus.in_action = 2'd0;
      bus.board_loaded = 1'b0;
      rst = 1'b1;
      repeat (3) tick();
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_err", 32'(bus.err), 32'd0);
      check("rst_ov", 32'(bus.out_valid), 32'd0);
      check("rst_score", 32'(bus.out_score), 32'd0);
      check("rst_starts", 32'({bus.swap_start, bus.scan_start, bus.drop_start}), 32'd0);
      check("rst_state", 32'(bus.dbg_state), 32'd0);
      rst = 1'b0;
      tick();

      // No matches at all: score 0, done two cycles after the last miss.
      set_cfg(0, 6'd3, -1, 1'b0);
      push_ten(1);
      load_board();
      finish_game("t1", 7'd0, 2'b00);
      check("t1_latency", ov_cyc - last_done_cyc, 32'd2);
      check("t1_swaps", n_swap, 32'd10);

      // One cascade of 3 per action.
      set_cfg(1, 6'd3, -1, 1'b0);
      push_ten(2);
      load_board();
      finish_game("t2", 7'd30, 2'b00);
      check("t2_drops", n_drop, 32'd10);
      check("t2_latency", ov_cyc - last_done_cyc, 32'd2);

      // Fourth action out of bounds.
      set_cfg(1, 6'd3, 4, 1'b0);
      push_ten(3);
      load_board();
      finish_game("t3", 7'd27, 2'b00);
      check("t3_scans", n_scan, 32'd18);
      check("t3_swaps", n_swap, 32'd10);

      // 4 cascades of 40 saturate the score.
      set_cfg(4, 6'd40, -1, 1'b0);
      push_ten(4);
      load_board();
      finish_game("t4", 7'd127, 2'b00);

      // Endless matches: cascade limit; actions trickle in to keep the watchdog quiet.
      set_cfg(1000, 6'd1, -1, 1'b0);
      load_board();
      for (int i = 0; i < 10; i++) begin
         push_act(6'(i * 3), 2'(i + 1), 1'b1);
         if (i < 9) repeat (80) tick();
      end
      finish_game("t5", 7'd127, 2'b00);
      check("t5_max_run", max_run, 32'd16);
      check("t5_drops", n_drop, 32'd160);

      // Drop engine hangs: watchdog ends the game with the partial score.
      set_cfg(1, 6'd5, -1, 1'b1);
      push_ten(6);
      load_board();
      finish_game("t6", 7'd5, 2'b01);
      check("t6_wd_cycles", busy_pre_ov, 32'd480);

      // Reset mid-game using the actions left over from the hung game.
      set_cfg(1, 6'd5, -1, 1'b0);
      load_board();
      check("t7_err_cleared", 32'(bus.err), 32'd0);
      repeat (20) tick();
      check("t7_busy_mid", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      tick();
      check("t7_busy", 32'(bus.busy), 32'd0);
      check("t7_err", 32'(bus.err), 32'd0);
      check("t7_ov", 32'(bus.out_valid), 32'd0);
      check("t7_score", 32'(bus.out_score), 32'd0);
      check("t7_starts", 32'({bus.swap_start, bus.scan_start, bus.drop_start}), 32'd0);
      check("t7_state", 32'(bus.dbg_state), 32'd0);
      rst = 1'b0;
      compare_obs("t7_act");
      exp_q.delete();
      repeat (50) tick();
      check("t7_no_ov", n_ov, 32'd0);

      // Eleventh action in one game is dropped and flagged.
      set_cfg(1, 6'd2, -1, 1'b0);
      push_ten(8);
      load_board();
      repeat (3) tick();
      push_act(6'h3f, 2'd3, 1'b0);
      check("t8_err_now", 32'(bus.err), 32'd2);
      finish_game("t8", 7'd20, 2'b10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
